// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: state geometry, lane addressing and loader FSM states.
`default_nettype none

package keccak_pkg;

   localparam int STATE_W = 1600;
   localparam int LANE_W  = 64;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      HAND = 2'd1,
      PERM = 2'd2
   } state_e;

   // Lane (x,y) occupies bits [LANE_W*lane_idx(x,y) +: LANE_W] of the state.
   function automatic int lane_idx(input int x, input int y);
      return x + 5 * y;
   endfunction

endpackage

`default_nettype wire

// File: rtl/keccak_absorb_buffer.sv
// =============================================================================
// Module     : keccak_absorb_buffer
// Description: Absorbs indexed chunks into a Keccak state and hands full rate
//              blocks to the permutation core over a valid/ready handshake.
// Revision   : 1.0 - initial release
// =============================================================================
`default_nettype none

module keccak_absorb_buffer
   import keccak_pkg::*;
#(
   parameter int DIN_W       = 200,
   parameter int NCHUNK      = 8,
   parameter int RATE_CHUNKS = 8,
   parameter bit ABSORB_XOR  = 1'b1,
   parameter int IDX_W       = $clog2(NCHUNK),
   localparam int STATE_BITS = DIN_W * NCHUNK
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pushin,
   input  logic [IDX_W-1:0]      dix,
   input  logic [DIN_W-1:0]      din,
   input  logic                  firstin,
   output logic                  stallout,
   output logic                  errout,
   output logic [STATE_BITS-1:0] st_out,
   output logic                  st_valid,
   input  logic                  st_ready,
   input  logic                  perm_done,
   input  logic [STATE_BITS-1:0] perm_state,
   output logic [15:0]           blk_cnt
);

   localparam logic [1:0]        c_FILL      = FILL;
   localparam logic [1:0]        c_HAND      = HAND;
   localparam logic [1:0]        c_PERM      = PERM;
   localparam logic [NCHUNK-1:0] c_RATE_MASK = {NCHUNK{1'b1}} >> (NCHUNK - RATE_CHUNKS);
   localparam logic [IDX_W:0]    c_RATE_LIM  = (IDX_W + 1)'(RATE_CHUNKS);

   logic [1:0]            r_state;
   logic [NCHUNK-1:0]     r_mask;
   logic [STATE_BITS-1:0] r_st;
   logic                  r_err;
   logic [15:0]           r_blk;

   logic [STATE_BITS-1:0] w_st_nxt;
   logic [NCHUNK-1:0]     w_onehot;
   logic [NCHUNK-1:0]     w_mask_acc;
   logic                  w_in_range;
   logic                  w_dup;
   logic                  w_first_ok;
   logic                  w_accept;
   logic                  w_complete;

   assign w_onehot   = NCHUNK'(1) << dix;
   assign w_in_range = {1'b0, dix} < c_RATE_LIM;
   assign w_dup      = |(r_mask & w_onehot);
   assign w_first_ok = !firstin || (r_mask == '0);
   assign w_accept   = pushin && (r_state == c_FILL) && w_in_range && !w_dup && w_first_ok;
   assign w_mask_acc = r_mask | w_onehot;
   assign w_complete = w_accept && ((w_mask_acc & c_RATE_MASK) == c_RATE_MASK);

   // firstin both wipes the state and writes din, so XOR mode degenerates to a plain load there.
   for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
      logic [DIN_W-1:0] w_old;
      logic [DIN_W-1:0] w_new;
      logic             w_hit;

      assign w_old = r_st[k*DIN_W +: DIN_W];
      assign w_hit = w_accept && (dix == IDX_W'(k));

      always_comb begin
         w_new = w_old;
         if (w_hit) begin
            w_new = (firstin || !ABSORB_XOR) ? din : (w_old ^ din);
         end else if (w_accept && firstin) begin
            w_new = '0;
         end
      end

      assign w_st_nxt[k*DIN_W +: DIN_W] = w_new;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_FILL;
         r_mask  <= '0;
         r_st    <= '0;
         r_err   <= 1'b0;
         r_blk   <= 16'd0;
      end else begin
         r_err <= pushin && !w_accept;
         case (r_state)
            c_FILL: begin
               if (w_accept) begin
                  r_st   <= w_st_nxt;
                  r_mask <= w_mask_acc;
                  if (w_complete) begin
                     r_state <= c_HAND;
                  end
               end
            end
            c_HAND: begin
               if (st_ready) begin
                  r_state <= c_PERM;
                  r_blk   <= r_blk + 16'd1;
               end
            end
            c_PERM: begin
               if (perm_done) begin
                  r_st    <= perm_state;
                  r_mask  <= '0;
                  r_state <= c_FILL;
               end
            end
            default: r_state <= c_FILL;
         endcase
      end
   end

   assign stallout = (r_state != c_FILL);
   assign st_valid = (r_state == c_HAND);
   assign errout   = r_err;
   assign st_out   = r_st;
   assign blk_cnt  = r_blk;

endmodule

`default_nettype wire

// File: tb/tb_keccak_absorb_buffer.sv
// Three loader variants (default, 5-chunk rate, overwrite mode) share one stimulus
// stream and are each checked every cycle against a behavioural model.
`default_nettype none

module tb_keccak_absorb_buffer;

   localparam int DW = 200;
   localparam int NC = 8;
   localparam int SW = DW * NC;
   localparam int NI = 3;

   localparam int RATE [NI] = '{8, 5, 8};
   localparam int XMOD [NI] = '{1, 1, 0};

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          pushin = 1'b0;
   logic [2:0]    dix = '0;
   logic [DW-1:0] din = '0;
   logic          firstin = 1'b0;
   logic          st_ready = 1'b0;
   logic          perm_done = 1'b0;
   logic [SW-1:0] perm_state = '0;

   logic [SW-1:0] so  [NI];
   logic          stl [NI];
   logic          er  [NI];
   logic          sv  [NI];
   logic [15:0]   bc  [NI];

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // model: per-instance chunk array, index set, phase (0 fill, 1 handoff, 2 permuting)
   logic [DW-1:0] m_st   [NI][NC];
   logic [NC-1:0] m_mask [NI];
   int            m_ph   [NI];
   logic          m_err  [NI];
   logic [15:0]   m_blk  [NI];

   always #5 clk = ~clk;

   keccak_absorb_buffer #(.DIN_W(DW), .NCHUNK(NC), .RATE_CHUNKS(8), .ABSORB_XOR(1'b1)) dut_a (
      .clk(clk), .reset(reset), .pushin(pushin), .dix(dix), .din(din), .firstin(firstin),
      .stallout(stl[0]), .errout(er[0]), .st_out(so[0]), .st_valid(sv[0]), .st_ready(st_ready),
      .perm_done(perm_done), .perm_state(perm_state), .blk_cnt(bc[0]));

   keccak_absorb_buffer #(.DIN_W(DW), .NCHUNK(NC), .RATE_CHUNKS(5), .ABSORB_XOR(1'b1)) dut_r5 (
      .clk(clk), .reset(reset), .pushin(pushin), .dix(dix), .din(din), .firstin(firstin),
      .stallout(stl[1]), .errout(er[1]), .st_out(so[1]), .st_valid(sv[1]), .st_ready(st_ready),
      .perm_done(perm_done), .perm_state(perm_state), .blk_cnt(bc[1]));

   keccak_absorb_buffer #(.DIN_W(DW), .NCHUNK(NC), .RATE_CHUNKS(8), .ABSORB_XOR(1'b0)) dut_ow (
      .clk(clk), .reset(reset), .pushin(pushin), .dix(dix), .din(din), .firstin(firstin),
      .stallout(stl[2]), .errout(er[2]), .st_out(so[2]), .st_valid(sv[2]), .st_ready(st_ready),
      .perm_done(perm_done), .perm_state(perm_state), .blk_cnt(bc[2]));

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd200();
      logic [DW-1:0] v;
      v = '0;
      for (int j = 0; j < 7; j++) v = (v << 32) | DW'($urandom);
      return v;
   endfunction

   function automatic logic [SW-1:0] rnd_state();
      logic [SW-1:0] v;
      v = '0;
      for (int j = 0; j < 50; j++) v = (v << 32) | SW'($urandom);
      return v;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < NC; j++) m_st[i][j] = '0;
            m_mask[i] = '0;
            m_ph[i]   = 0;
            m_err[i]  = 1'b0;
            m_blk[i]  = 16'd0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            int  p;
            bit  acc;
            bit  full;
            p = m_ph[i];
            m_err[i] = 1'b0;
            if (pushin) begin
               acc = (p == 0) && (int'(dix) < RATE[i]) && !m_mask[i][dix] &&
                     (!firstin || m_mask[i] == '0);
               if (acc) begin
                  if (firstin) for (int j = 0; j < NC; j++) m_st[i][j] = '0;
                  if (XMOD[i] == 1) m_st[i][dix] = m_st[i][dix] ^ din;
                  else              m_st[i][dix] = din;
                  m_mask[i][dix] = 1'b1;
                  full = 1'b1;
                  for (int j = 0; j < RATE[i]; j++) if (!m_mask[i][j]) full = 1'b0;
                  if (full) m_ph[i] = 1;
               end else begin
                  m_err[i] = 1'b1;
               end
            end
            if (p == 1 && st_ready) begin
               m_ph[i]  = 2;
               m_blk[i] = m_blk[i] + 16'd1;
            end
            if (p == 2 && perm_done) begin
               for (int j = 0; j < NC; j++) m_st[i][j] = perm_state[j*DW +: DW];
               m_mask[i] = '0;
               m_ph[i]   = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NI; i++) begin
            chk($sformatf("i%0d_stallout", i), DW'(stl[i]), DW'(m_ph[i] != 0));
            chk($sformatf("i%0d_st_valid", i), DW'(sv[i]), DW'(m_ph[i] == 1));
            chk($sformatf("i%0d_errout", i), DW'(er[i]), DW'(m_err[i]));
            chk($sformatf("i%0d_blk_cnt", i), DW'(bc[i]), DW'(m_blk[i]));
            for (int k = 0; k < NC; k++)
               chk($sformatf("i%0d_chunk%0d", i, k), so[i][k*DW +: DW], m_st[i][k]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int d, input logic [DW-1:0] v, input bit f);
      pushin  = 1'b1;
      dix     = 3'(d);
      din     = v;
      firstin = f;
      step();
      pushin  = 1'b0;
      firstin = 1'b0;
   endtask

   initial begin
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk_en = 1'b1;

      @(negedge clk);
      chk("lit_reset_valid", DW'(sv[0]), '0);
      chk("lit_reset_blk", DW'(bc[0]), '0);
      chk("lit_reset_chunk0", so[0][0 +: DW], '0);

      push(0, 200'h1, 1'b1);
      for (int k = 1; k < 8; k++) begin
         if (k == 7) begin
            @(negedge clk);
            chk("lit_valid_before_last", DW'(sv[0]), '0);
         end
         push(k, DW'(k), 1'b0);
      end
      @(negedge clk);
      chk("lit_valid_after_last", DW'(sv[0]), DW'(1));
      chk("lit_stall_after_last", DW'(stl[0]), DW'(1));
      chk("lit_chunk0", so[0][0 +: DW], 200'h1);
      for (int k = 1; k < 8; k++) chk("lit_chunk_k", so[0][k*DW +: DW], DW'(k));
      chk("lit_r5_valid", DW'(sv[1]), DW'(1));

      pushin = 1'b1; dix = 3'd0; din = 200'h5;
      repeat (10) begin
         step();
         @(negedge clk);
         chk("lit_hand_hold", DW'(sv[0]), DW'(1));
         chk("lit_hand_reject", DW'(er[0]), DW'(1));
      end
      pushin = 1'b0;
      st_ready = 1'b1;
      step();
      st_ready = 1'b0;
      @(negedge clk);
      chk("lit_perm_valid", DW'(sv[0]), '0);
      chk("lit_blk1", DW'(bc[0]), DW'(1));

      perm_done = 1'b1; perm_state = '1;
      pushin = 1'b1; dix = 3'd0; din = 200'h9;
      step();
      perm_done = 1'b0; pushin = 1'b0;
      @(negedge clk);
      chk("lit_fill_stall", DW'(stl[0]), '0);
      chk("lit_perm_push_err", DW'(er[0]), DW'(1));
      chk("lit_perm_chunk0", so[0][0 +: DW], '1);

      push(3, 200'hFF, 1'b0);
      @(negedge clk);
      chk("lit_xor_chunk3", so[0][3*DW +: DW], ~200'hFF);
      chk("lit_ow_chunk3", so[2][3*DW +: DW], 200'hFF);
      chk("lit_xor_chunk2", so[0][2*DW +: DW], '1);

      push(6, 200'h7, 1'b0);
      @(negedge clk);
      chk("lit_r5_range_err", DW'(er[1]), DW'(1));
      chk("lit_r5_chunk6", so[1][6*DW +: DW], '1);

      push(3, 200'h1, 1'b0);
      @(negedge clk);
      chk("lit_dup_err", DW'(er[0]), DW'(1));
      chk("lit_dup_chunk3", so[0][3*DW +: DW], ~200'hFF);

      push(2, 200'h1, 1'b1);
      @(negedge clk);
      chk("lit_first_mid_err", DW'(er[0]), DW'(1));
      chk("lit_first_mid_chunk2", so[0][2*DW +: DW], '1);

      push(0, rnd200(), 1'b0);
      push(1, rnd200(), 1'b0);
      push(2, rnd200(), 1'b0);
      push(4, rnd200(), 1'b0);
      push(5, rnd200(), 1'b0);
      push(7, rnd200(), 1'b0);
      @(negedge clk);
      chk("lit_full_valid", DW'(sv[0]), DW'(1));
      chk("lit_r5_full_valid", DW'(sv[1]), DW'(1));
      for (int k = 5; k < 8; k++) chk("lit_r5_capacity", so[1][k*DW +: DW], '1);

      st_ready = 1'b1;
      step();
      st_ready = 1'b0;
      @(negedge clk);
      chk("lit_blk2", DW'(bc[0]), DW'(2));
      #2 reset = 1'b1;
      #1;
      chk("lit_async_stall", DW'(stl[0]), '0);
      chk("lit_async_blk", DW'(bc[0]), '0);
      chk("lit_async_chunk0", so[0][0 +: DW], '0);
      @(posedge clk);
      #1 reset = 1'b0;
      perm_done = 1'b1;
      perm_state = rnd_state();
      step();
      perm_done = 1'b0;
      @(negedge clk);
      chk("lit_ignored_perm_chunk0", so[0][0 +: DW], '0);
      chk("lit_ignored_perm_stall", DW'(stl[0]), '0);

      repeat (3000) begin
         pushin     = ($urandom_range(0, 3) != 0);
         dix        = 3'($urandom_range(0, 7));
         din        = rnd200();
         firstin    = ($urandom_range(0, 9) == 0);
         st_ready   = $urandom_range(0, 1) == 1;
         perm_done  = ($urandom_range(0, 2) == 0);
         perm_state = rnd_state();
         step();
      end
      pushin = 1'b0; perm_done = 1'b0; st_ready = 1'b0; firstin = 1'b0;
      step();
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
